// File: rtl/pack_z_pipe.sv
// Two-stage float packer: round (stage 1), then bias/classify/pack (stage 2).
// Valid/ready handshake with one global advance; the bypass word travels with the same latency.
module pack_z_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int BIAS   = 127,
    parameter int WORD_W = 1 + EXP_W + MAN_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_bypass,
    input  logic [WORD_W-1:0]       in_raw,
    input  logic                    in_sign,
    input  logic signed [EXP_W+1:0] in_exp,
    input  logic [MAN_W+3:0]        in_man,
    input  logic [1:0]              in_rmode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_W-1:0]       out_word,
    output logic [2:0]              out_flags
);

    localparam int EW2 = EXP_W + 2;
    localparam int MW1 = MAN_W + 1;
    localparam logic signed [EW2-1:0] BIAS_S    = EW2'(BIAS);
    localparam logic signed [EW2-1:0] EXP_SAT_S = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] EMIN_S    = EW2'(1 - BIAS);
    localparam logic signed [EW2-1:0] ZERO_S    = '0;
    localparam logic signed [EW2-1:0] ONE_S     = EW2'(1);

    function automatic logic round_inc(input logic [1:0] rmode, input logic sign,
                                       input logic lsb, input logic g, input logic rs);
        logic inc;
        case (rmode)
            2'd0:    inc = g & (rs | lsb);
            2'd1:    inc = 1'b0;
            2'd2:    inc = ~sign & (g | rs);
            default: inc = sign & (g | rs);
        endcase
        return inc;
    endfunction

    // Directed modes saturate to the largest finite value when rounding away from infinity.
    function automatic logic [WORD_W-1:0] sat_word(input logic sign, input logic [1:0] rmode);
        logic to_inf;
        logic [WORD_W-1:0] w;
        to_inf = (rmode == 2'd0) | ((rmode == 2'd2) & ~sign) | ((rmode == 2'd3) & sign);
        if (to_inf) w = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else        w = {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        return w;
    endfunction

    function automatic logic [WORD_W+2:0] pack(input logic byp, input logic [WORD_W-1:0] raw,
                                               input logic sign, input logic [1:0] rmode,
                                               input logic signed [EW2-1:0] e,
                                               input logic [MW1-1:0] man, input logic inexact);
        logic signed [EW2-1:0] biased;
        logic [WORD_W+2:0] r;
        biased = e + BIAS_S;
        if (byp)
            r = {3'b000, raw};
        else if (man == '0)
            r = {3'b000, sign, {(WORD_W-1){1'b0}}};
        else if (biased >= EXP_SAT_S)
            r = {3'b101, sat_word(sign, rmode)};
        else if ((e == EMIN_S) && !man[MAN_W])
            r = {1'b0, inexact, inexact, sign, {EXP_W{1'b0}}, man[MAN_W-1:0]};
        else if (biased <= ZERO_S)
            r = {3'b011, sign, {(WORD_W-1){1'b0}}};
        else
            r = {2'b00, inexact, sign, biased[EXP_W-1:0], man[MAN_W-1:0]};
        return r;
    endfunction

    logic adv;

    logic                  inc_p0;
    logic [MW1:0]          sum_p0;
    logic signed [EW2-1:0] exp_p0;
    logic [MW1-1:0]        man_p0;

    logic                  vld_p1_q, vld_p1_d;
    logic                  byp_p1_q, byp_p1_d;
    logic [WORD_W-1:0]     raw_p1_q, raw_p1_d;
    logic                  sign_p1_q, sign_p1_d;
    logic [1:0]            rmode_p1_q, rmode_p1_d;
    logic signed [EW2-1:0] exp_p1_q, exp_p1_d;
    logic [MW1-1:0]        man_p1_q, man_p1_d;
    logic                  inx_p1_q, inx_p1_d;

    logic                  vld_p2_q, vld_p2_d;
    logic [WORD_W-1:0]     word_p2_q, word_p2_d;
    logic [2:0]            flags_p2_q, flags_p2_d;

    assign adv       = ~vld_p2_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p2_q;
    assign out_word  = word_p2_q;
    assign out_flags = flags_p2_q;

    always_comb begin
        // stage 0 -> 1: round, renormalise on carry-out
        inc_p0 = round_inc(in_rmode, in_sign, in_man[3], in_man[2], in_man[1] | in_man[0]);
        sum_p0 = {1'b0, in_man[MAN_W+3:3]} + {{MW1{1'b0}}, inc_p0};
        exp_p0 = sum_p0[MW1] ? (in_exp + ONE_S) : in_exp;
        man_p0 = sum_p0[MW1] ? sum_p0[MW1:1] : sum_p0[MW1-1:0];

        vld_p1_d   = vld_p1_q;
        byp_p1_d   = byp_p1_q;
        raw_p1_d   = raw_p1_q;
        sign_p1_d  = sign_p1_q;
        rmode_p1_d = rmode_p1_q;
        exp_p1_d   = exp_p1_q;
        man_p1_d   = man_p1_q;
        inx_p1_d   = inx_p1_q;
        vld_p2_d   = vld_p2_q;
        word_p2_d  = word_p2_q;
        flags_p2_d = flags_p2_q;

        if (adv) begin
            vld_p1_d = in_valid;
            if (in_valid) begin
                byp_p1_d   = in_bypass;
                raw_p1_d   = in_raw;
                sign_p1_d  = in_sign;
                rmode_p1_d = in_rmode;
                exp_p1_d   = exp_p0;
                man_p1_d   = man_p0;
                inx_p1_d   = |in_man[2:0];
            end
            // stage 1 -> 2: bias, classify, pack
            vld_p2_d = vld_p1_q;
            if (vld_p1_q)
                {flags_p2_d, word_p2_d} = pack(byp_p1_q, raw_p1_q, sign_p1_q, rmode_p1_q,
                                               exp_p1_q, man_p1_q, inx_p1_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            word_p2_q  <= '0;
            flags_p2_q <= '0;
        end else begin
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p2_d;
            word_p2_q  <= word_p2_d;
            flags_p2_q <= flags_p2_d;
        end
    end

    always_ff @(posedge clock) begin
        byp_p1_q   <= byp_p1_d;
        raw_p1_q   <= raw_p1_d;
        sign_p1_q  <= sign_p1_d;
        rmode_p1_q <= rmode_p1_d;
        exp_p1_q   <= exp_p1_d;
        man_p1_q   <= man_p1_d;
        inx_p1_q   <= inx_p1_d;
    end

endmodule

// File: doc/pack_z_pipe.md
Name: pack_z_pipe

Overview:
Parametrised, pipelined successor to the single-cycle float packer at the end of the multiplier and normaliser chain. It takes a normalised sign/exponent/mantissa with guard, round and sticky bits. It applies a selectable rounding mode, renormalises on rounding carry, biases the exponent, and handles overflow, subnormal and underflow cases. It emits a packed IEEE-style word with status flags. A valid/ready handshake allows it to sit between stalling pipeline stages; a bypass path carries idle/raw words through with the same latency.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width (hidden bit excluded)
BIAS, 127, exponent bias; must equal 2^(EXP_W-1)-1
WORD_W, 1+EXP_W+MAN_W, packed output width (derived, do not override)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  block accepts input this cycle
in_bypass  in  1  1: pass in_raw through unmodified (idle path)
in_raw  in  WORD_W  raw word for the bypass path
in_sign  in  1  sign
in_exp  in  EXP_W+2  signed, unbiased exponent
in_man  in  MAN_W+4  [MAN_W+3] hidden bit, [MAN_W+2:3] fraction, [2] guard, [1] round, [0] sticky
in_rmode  in  2  0 RNE, 1 RTZ, 2 toward +inf, 3 toward -inf
out_valid  out  1  output valid
out_ready  in  1  downstream accepts output
out_word  out  WORD_W  {sign, biased exponent, fraction}
out_flags  out  3  {overflow, underflow, inexact}

Behaviour:
- Reset (async, active-high): both stage valids, out_valid, out_word and out_flags go to 0. In-flight items are discarded. in_ready is 1 after reset.
- Pipeline: two registered stages; latency is exactly 2 accepted-advance cycles.
- Global advance enable: adv = !out_valid | out_ready. in_ready = adv. A transfer occurs on in_valid & in_ready. All stages hold when adv=0, and out_word/out_flags must stay stable while out_valid & !out_ready.
- Bubbles: they propagate as valid=0. Throughput is 1 item per cycle when out_ready is held high.
- Stage 1, rounding:
  - lsb = in_man[3], g = in_man[2], rs = in_man[1] | in_man[0], inexact = g | rs.
  - Increment rule: RNE increments when g & (rs | lsb). RTZ never increments. +inf mode increments when !sign & inexact. -inf mode increments when sign & inexact.
  - Add is performed on in_man[MAN_W+3:3] at MAN_W+2 bits.
  - Carry-out: shift the mantissa right 1 and add 1 to the exponent.
- Stage 2, packing: biased = exp + BIAS, computed signed at EXP_W+2 bits. Priority is top to bottom:
  - a) bypass=1: out_word = in_raw, flags = 0.
  - b) Mantissa all zero: out_word = {sign, 0, 0}, flags = 0.
  - c) biased >= 2^EXP_W - 1 (overflow), flags = 1,0,1:
    - RNE: ±inf.
    - RTZ: ±max finite (exponent all-ones minus 1, fraction all ones).
    - +inf mode: +inf if positive, -max finite if negative.
    - -inf mode: -inf if negative, +max finite if positive.
  - d) exp == 1-BIAS and hidden bit 0 (subnormal): exponent field 0, fraction kept, underflow = inexact.
  - e) biased <= 0 otherwise: flush to signed zero, flags = 0,1,1.
  - f) Normal: {sign, biased[EXP_W-1:0], fraction[MAN_W-1:0]}, flags = 0,0,inexact.
- Bypass, sign and rmode are carried alongside the data through both stages. There is no cross-item state.
- Simultaneous input transfer and output pop in one cycle is legal; no item is lost or duplicated.

Test Plan:
- Exact 1.0: sign 0, exp 0, man 0x4000000, RNE -> out_word 0x3F800000, flags 000, out_valid 2 cycles after acceptance.
- Rounding carry: exp 0, man 0x7FFFFFC (fraction all ones, g=1), RNE -> 0x40000000, flags 001. The same input with RTZ -> 0x3FFFFFFF.
- Overflow: exp 128, man 0x4000000.
  - RNE -> 0x7F800000, flags 101.
  - RTZ -> 0x7F7FFFFF.
  - sign 1, +inf mode -> 0xFF7FFFFF.
- Subnormal/underflow:
  - exp -126, man 0x2000000 -> 0x00400000.
  - exp -140 -> 0x00000000, flags 011.
  - Bypass with in_raw 0xDEADBEEF -> 0xDEADBEEF, flags 000.
- Backpressure: push 4 items back to back with out_ready low for 3 cycles -> in_ready falls, out_word holds stable, all 4 items emerge in order with no loss.
- Reset mid-flight: assert reset with 2 items in the pipe -> out_valid 0 immediately (async). After release, the next accepted item emerges 2 cycles later.
